// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key 2-flop synchronizer, debounce filter,
// press/release pulses and hold-to-repeat pulses for active-low DE-series keys.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_P  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;

  // Inverting here makes everything downstream active-high (1 = pressed).
  always_ff @(posedge CLOCK_50) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // two synchronizer stages into one.
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~KEY;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_toggle;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_rtmr;
    logic [CW-1:0] w_rtmr_nxt;
    logic          r_repeat;
    logic          w_repeat_nxt;

    assign w_toggle = (r_sync2[g] != r_level) && (r_cnt == DB_LAST);

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (r_sync2[g] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
          r_cnt     <= '0;
          r_level   <= ~r_level;
          r_press   <= ~r_level;
          r_release <= r_level;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_state  <= ST_IDLE;
        r_rtmr   <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_rtmr   <= w_rtmr_nxt;
        r_repeat <= w_repeat_nxt;
      end
    end

    // HOLD/REPEAT imply key_level=1, so a toggle there is always the release,
    // and it takes priority over a timer expiring on the same edge.
    always_comb begin
      // NOTE: every output of this block is assigned a default first, so no
      // path through the case statement can leave a value held (a latch).
      w_state_nxt  = r_state;
      w_rtmr_nxt   = r_rtmr;
      w_repeat_nxt = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_toggle && !r_level) begin
            w_state_nxt = ST_HOLD;
            w_rtmr_nxt  = '0;
          end
        end
        ST_HOLD: begin
          if (w_toggle) begin
            w_state_nxt = ST_IDLE;
            w_rtmr_nxt  = '0;
          end else if (r_rtmr == HLD_LAST) begin
            w_state_nxt  = ST_REPEAT;
            w_rtmr_nxt   = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_rtmr_nxt = r_rtmr + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (w_toggle) begin
            w_state_nxt = ST_IDLE;
            w_rtmr_nxt  = '0;
          end else if (r_rtmr == RPT_LAST) begin
            w_rtmr_nxt   = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_rtmr_nxt = r_rtmr + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_rtmr_nxt  = '0;
        end
      endcase
    end

    assign key_level[g]   = r_level;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
    assign key_repeat[g]  = r_repeat;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity,
// checked by a window-based reference model feeding a per-cycle scoreboard.
module tb_key_conditioner;

  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam int MAXC = 8192;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rep;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [N-1:0] KEY;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_repeat;

  int   cyc     = 0;
  int   n_err   = 0;
  int   n_check = 0;
  exp_t sb_q[$];

  key_conditioner #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_check++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a key's level flips once the last DB synchronized
  // samples all disagree with it and none of them predate the previous
  // flip or reset; repeats fall on press+HOLD+j*REP while still held.
  logic [N-1:0] xh [MAXC];
  int           last_ev  [N];
  int           press_at [N];
  logic [N-1:0] m_level = '0;

  initial begin
    forever begin
      exp_t e;
      int   t;
      bit   tog;
      @(posedge clk);
      cyc++;
      t = cyc;
      e = '0;
      if (reset) begin
        m_level = '0;
        xh[t % MAXC] = '0;
        xh[(t - 1) % MAXC] = '0;
        for (int l = 0; l < N; l++) last_ev[l] = t;
      end else begin
        xh[t % MAXC] = ~KEY;
        for (int l = 0; l < N; l++) begin
          tog = (t - last_ev[l] >= DB);
          if (tog)
            for (int i = 0; i < DB; i++)
              if (xh[(t - 2 - i) % MAXC][l] == m_level[l]) tog = 0;
          if (tog) begin
            last_ev[l] = t;
            if (m_level[l]) begin
              e.rel[l] = 1'b1;
            end else begin
              e.press[l]  = 1'b1;
              press_at[l] = t;
            end
            m_level[l] = ~m_level[l];
          end else if (m_level[l] && (t - press_at[l] >= HOLD) &&
                       ((t - press_at[l] - HOLD) % REP == 0)) begin
            e.rep[l] = 1'b1;
          end
        end
      end
      e.level = m_level;
      sb_q.push_back(e);
    end
  end

  // Monitor: pops one expectation for every cycle the DUT presents outputs.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        check("sb_empty", 16'd1, 16'd0);
      end else begin
        e = sb_q.pop_front();
        check("outputs", {key_level, key_press, key_release, key_repeat}, e);
      end
    end
  end

  task automatic at_edge(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("edge_align", 16'(cyc), 16'(target));
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int p;
    int r;
    int dur [N];

    reset = 1'b1;
    KEY   = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    at_edge(cyc + 1);
    check("reset_outputs", 16'({key_level, key_press, key_release, key_repeat}), 16'd0);
    repeat (2) @(negedge clk);

    // Clean press on KEY[0].
    KEY[0] = 1'b0;
    k = cyc + 1;
    at_edge(k + 4);
    check("s1_level_early", 16'(key_level), 16'd0);
    at_edge(k + 5);
    check("s1_press", 16'(key_press), 16'b0001);
    check("s1_level", 16'(key_level), 16'b0001);
    at_edge(k + 6);
    check("s1_press_width", 16'(key_press), 16'd0);
    @(negedge clk);
    KEY[0] = 1'b1;
    k = cyc + 1;
    at_edge(k + 5);
    check("s1_release", 16'(key_release), 16'b0001);

    // Bounce on KEY[1]: low 3, high 1, then low.
    @(negedge clk);
    KEY[1] = 1'b0;
    repeat (3) @(negedge clk);
    KEY[1] = 1'b1;
    @(negedge clk);
    KEY[1] = 1'b0;
    k = cyc + 1;
    at_edge(k + 4);
    check("s2_no_early", 16'(key_level), 16'd0);
    at_edge(k + 5);
    check("s2_press", 16'(key_press), 16'b0010);
    @(negedge clk);
    KEY[1] = 1'b1;
    k = cyc + 1;
    at_edge(k + 5);
    check("s2_release", 16'(key_release), 16'b0010);

    // Hold/repeat on KEY[2].
    @(negedge clk);
    KEY[2] = 1'b0;
    p = cyc + 1 + 5;
    at_edge(p);
    check("s3_press", 16'(key_press), 16'b0100);
    at_edge(p + 9);
    check("s3_no_rep_early", 16'(key_repeat), 16'd0);
    at_edge(p + 10);
    check("s3_rep_first", 16'(key_repeat), 16'b0100);
    at_edge(p + 13);
    check("s3_rep_second", 16'(key_repeat), 16'b0100);
    at_edge(p + 28);
    check("s3_rep_p28", 16'(key_repeat), 16'b0100);
    at_edge(p + 30);
    @(negedge clk);
    KEY[2] = 1'b1;
    k = cyc + 1;
    at_edge(k + 5);
    check("s3_release", 16'(key_release), 16'b0100);
    check("s3_release_norep", 16'(key_repeat), 16'd0);
    at_edge(k + 6);
    check("s3_reps_stop", 16'(key_repeat), 16'd0);

    // Release lands on the edge the hold timer expires.
    @(negedge clk);
    KEY[0] = 1'b0;
    p = cyc + 1 + 5;
    at_edge(p + 4);
    @(negedge clk);
    KEY[0] = 1'b1;
    at_edge(p + 10);
    check("s4_release", 16'(key_release), 16'b0001);
    check("s4_no_repeat", 16'(key_repeat), 16'd0);
    at_edge(p + 13);
    check("s4_idle", 16'(key_repeat), 16'd0);

    // Reset while KEY[3] is held in REPEAT.
    @(negedge clk);
    KEY[3] = 1'b0;
    p = cyc + 1 + 5;
    at_edge(p + 12);
    @(negedge clk);
    reset = 1'b1;
    r = cyc + 1;
    at_edge(r);
    check("s5_reset_outputs", 16'({key_level, key_press, key_release, key_repeat}), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    at_edge(r + 5);
    check("s5_no_early_press", 16'(key_press), 16'd0);
    at_edge(r + 6);
    check("s5_repress", 16'(key_press), 16'b1000);
    @(negedge clk);
    KEY[3] = 1'b1;
    k = cyc + 1;
    at_edge(k + 5);
    check("s5_release", 16'(key_release), 16'b1000);

    // Simultaneous press on KEY[0] and KEY[3].
    @(negedge clk);
    KEY[0] = 1'b0;
    KEY[3] = 1'b0;
    k = cyc + 1;
    at_edge(k + 5);
    check("s6_press", 16'(key_press), 16'b1001);
    at_edge(k + 6);
    check("s6_press_width", 16'(key_press), 16'd0);
    @(negedge clk);
    KEY = '1;
    k = cyc + 1;
    at_edge(k + 5);
    check("s6_release", 16'(key_release), 16'b1001);

    // Random bouncy/long activity with occasional resets.
    for (int l = 0; l < N; l++) dur[l] = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int l = 0; l < N; l++) begin
        if (dur[l] == 0) begin
          KEY[l] = ~KEY[l];
          dur[l] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5))
                                                : int'($urandom_range(6, 40));
        end else begin
          dur[l]--;
        end
      end
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    KEY   = '1;
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("final_idle", 16'(key_level), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_check);
    $finish;
  end

endmodule
